rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters and drives a registered one-hot grant. It produces a 3-bit winner index, then decodes it 3-to-8 into per-requester grant lines. It sits between eight client blocks and the shared resource they contend for. The resource consumes `gnt_idx` as its select and `gnt` as per-client enables.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may hold the grant. Legal range is 1..16.
- `clk` input, 1 bit: single clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset, sampled on the `clk` rising edge.
- `req` input, 8 bits: request lines, bit i is requester i. A requester holds its bit high until it no longer needs the resource.
- `gnt` output, 8 bits: registered one-hot grant. All zeros when idle.
- `gnt_idx` output, 3 bits: registered index of the granted requester.
- `gnt_valid` output, 1 bit: high while a grant is active. It equals `|gnt`.

## Operation
- **States:**
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
- **Internal registers:**
  - `last[2:0]`: most recent winner.
  - `hold_cnt[3:0]`: cycles the current owner has held the grant.
- **Round-robin search:** examine requesters `last+1`, `last+2`, …, `last+8`, all modulo 8 (3-bit wrap, so 7+1 = 0). The first requester with `req` high wins.
- **IDLE:**
  - If `req` ≠ 0: next state is GRANT, with `gnt_idx`/`last` set to the search winner and `hold_cnt` = 0.
  - Otherwise: stay in IDLE.
- **GRANT, release condition:** either `req[gnt_idx]` = 0 (owner dropped its request), or `hold_cnt` = `HOLD_MAX`−1 (timeout).
- **GRANT, no release:** `hold_cnt` increments and the grant is unchanged.
- **GRANT, release:** run the search with the current owner excluded.
  - If another requester is found: it is granted on the same edge (no idle bubble) and `hold_cnt` resets to 0.
  - If none is found and the owner still requests (timeout case): the owner is re-granted and `hold_cnt` resets to 0.
  - If none is found and the owner has dropped: go to IDLE; `gnt`, `gnt_valid` and `gnt_idx` go to 0, and `last` keeps the old owner.
- **Decoding:** `gnt` is the 3-to-8 decode of `gnt_idx`, enabled by `gnt_valid`. Exactly one `gnt` bit is high in GRANT, and none in IDLE.
- **Counter width:** `hold_cnt` is 4 bits and never exceeds `HOLD_MAX`−1.
- **`HOLD_MAX` = 1:** every GRANT cycle is a release cycle, so the grant rotates every cycle among active requesters.
- **Reset, from any state including mid-grant:**
  - `gnt` = 8'h00, `gnt_idx` = 3'd0, `gnt_valid` = 0.
  - State = IDLE, `hold_cnt` = 0.
  - `last` = 3'd7, so requester 0 has first priority after reset.
- **Request timing:** requests arriving mid-grant are not lost. They are considered at the next release. Combinational `req` glitches between edges are ignored.

## Timing
- **Grant latency:** `req` sampled high at edge N in IDLE gives `gnt` valid after edge N (visible in cycle N+1). Latency is 1 cycle.
- **Release:** owner drops `req` before edge N gives the new owner's `gnt` after edge N. There is zero dead cycles between owners when another request is pending.
- **Timeout:** a continuously requesting owner holds `gnt` for exactly `HOLD_MAX` cycles, then is switched out if another requester is active.
- **Simultaneous events:** a release and a new request on the same edge resolve in one search. A `rst_n` low edge overrides everything.
- **Combinational paths:** none from `req` to outputs. All outputs come directly from flops or from decode of flops.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ` = 8 and `IDX_W` = 3.
  - State enum `arb_state_t` {ST_IDLE, ST_GRANT}.
  - Reset constant `LAST_RST` = 3'd7.
- **Sub-module `grant_decoder3to8`:** combinational 3-to-8 decoder with enable. Inputs `idx[2:0]` and `en`; output `onehot[7:0]`. All zeros when `en` = 0. Instantiated once.
- **Search logic:** a priority rotate (rotate `req` by `last`+1, find first set bit, add back modulo 8). Implemented as a function in the arbiter, not as a separate module.

## Test plan
1. **Reset then single request:** `req` = 8'h10 → one cycle later `gnt` = 8'h10, `gnt_idx` = 4, `gnt_valid` = 1. Drop `req` → `gnt` = 8'h00 next cycle.
2. **Fairness:** `req` = 8'hFF held for 64 cycles with `HOLD_MAX` = 8 → grants are 0,1,2,…,7, each for exactly 8 cycles, with no gaps and `gnt` always one-hot.
3. **Wrap-around:** owner 6 releases while `req` = 8'h41 → next grant is 0, not 6. Later, owner 0 releases with `req` = 8'h41 → grant goes to 6.
4. **Timeout with sole requester:** `req` = 8'h02 held for 20 cycles → `gnt` = 8'h02 continuously and `gnt_valid` never drops.
5. **Back-to-back handoff:** owner 3 drops as `req` becomes 8'h20 on the same edge → `gnt` goes 8'h08 → 8'h20 with no all-zero cycle.
6. **Mid-grant reset:** during an active grant to requester 5, pulse `rst_n` low for 1 cycle → `gnt` = 8'h00 after that edge. Then with `req` = 8'hA1, the first grant is 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
// Holds the state encoding, index widths and the post-reset priority pointer.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // The pointer starts at 7 so that requester 0 is searched first after reset.
    localparam logic [IDX_W-1:0] LAST_RST = 3'd7;
endpackage

// File: rtl/grant_decoder3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; zero latency, no flow control.
// Produces all zeros when en is low.
module grant_decoder3to8
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = N_REQ'(1) << idx;
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with a registered one-hot grant and hold timeout.
// Latency: one cycle from request to grant; owners hand off on the same edge with no idle bubble.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [3:0]       hold_cnt, hold_nxt;
    logic             release_now;
    logic [3:0]       pick_all;
    logic [3:0]       pick_others;

    // Returns {found, winner}: rotate so base+1 lands at bit 0, take the lowest set bit, rotate back.
    function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] base);
        logic [IDX_W-1:0] sh;
        logic [N_REQ-1:0] rot;
        logic             found;
        logic [IDX_W-1:0] off;
        sh    = base + 3'd1;
        rot   = 8'({r, r} >> sh);
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = 3'(i);
            end
        end
        return {found, off + sh};
    endfunction

    assign pick_all    = rr_pick(req, last);
    assign pick_others = rr_pick(req & ~gnt, last);
    assign release_now = !req[gnt_idx] || (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        idx_nxt   = gnt_idx;
        hold_nxt  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_all[3]) begin
                    state_nxt = ST_GRANT;
                    idx_nxt   = pick_all[2:0];
                    last_nxt  = pick_all[2:0];
                    hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (!release_now) begin
                    hold_nxt = hold_cnt + 4'd1;
                end else if (pick_others[3]) begin
                    idx_nxt  = pick_others[2:0];
                    last_nxt = pick_others[2:0];
                    hold_nxt = '0;
                end else if (req[gnt_idx]) begin
                    hold_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last     <= LAST_RST;
            gnt_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            gnt_idx  <= idx_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign gnt_valid = (state == ST_GRANT);

    grant_decoder3to8 u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt)
    );
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, single request, fairness, wrap-around,
// sole-requester timeout, same-edge handoff and mid-grant reset.
module tb_rr_arbiter8;
    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks;
    int errors;

    rr_arbiter8 #(.HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_vld", 32'(gnt_valid), 32'd0);

        // Single request and drop
        rst_n = 1'b1;
        req   = 8'h10;
        tick();
        chk("single_gnt", 32'(gnt), 32'h10);
        chk("single_idx", 32'(gnt_idx), 32'd4);
        chk("single_vld", 32'(gnt_valid), 32'd1);
        req = 8'h00;
        tick();
        chk("drop_gnt", 32'(gnt), 32'h00);
        chk("drop_vld", 32'(gnt_valid), 32'd0);
        chk("drop_idx", 32'(gnt_idx), 32'd0);

        // Fairness: all requesting, 8 cycles each starting at 0 after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int c = 0; c < 64; c++) begin
            tick();
            chk("fair_gnt", 32'(gnt), 32'(8'h01 << (c / 8)));
            chk("fair_vld", 32'(gnt_valid), 32'd1);
        end
        req = 8'h00;
        tick();
        chk("fair_idle", 32'(gnt), 32'h00);

        // Wrap-around: 6 times out with 0 pending, then 0 times out back to 6
        req = 8'h40;
        tick();
        chk("wrap_own6", 32'(gnt), 32'h40);
        req = 8'h41;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("wrap_hold6", 32'(gnt), 32'h40);
        end
        tick();
        chk("wrap_to0", 32'(gnt), 32'h01);
        chk("wrap_to0_idx", 32'(gnt_idx), 32'd0);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("wrap_hold0", 32'(gnt), 32'h01);
        end
        tick();
        chk("wrap_to6", 32'(gnt), 32'h40);
        chk("wrap_to6_idx", 32'(gnt_idx), 32'd6);
        req = 8'h00;
        tick();
        chk("wrap_idle", 32'(gnt), 32'h00);

        // Sole requester keeps the grant across timeouts
        req = 8'h02;
        tick();
        chk("sole_first", 32'(gnt), 32'h02);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("sole_gnt", 32'(gnt), 32'h02);
            chk("sole_vld", 32'(gnt_valid), 32'd1);
        end
        req = 8'h00;
        tick();
        chk("sole_idle", 32'(gnt), 32'h00);

        // Same-edge handoff from 3 to 5
        req = 8'h08;
        tick();
        chk("hand_own3", 32'(gnt), 32'h08);
        req = 8'h20;
        tick();
        chk("hand_to5", 32'(gnt), 32'h20);
        chk("hand_to5_vld", 32'(gnt_valid), 32'd1);
        tick();
        chk("hand_keep5", 32'(gnt), 32'h20);

        // Reset in the middle of a grant to 5
        rst_n = 1'b0;
        req   = 8'hA1;
        tick();
        chk("mrst_gnt", 32'(gnt), 32'h00);
        chk("mrst_idx", 32'(gnt_idx), 32'd0);
        chk("mrst_vld", 32'(gnt_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mrst_first", 32'(gnt), 32'h01);
        chk("mrst_first_idx", 32'(gnt_idx), 32'd0);
        chk("mrst_first_vld", 32'(gnt_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
